// File: rtl/mips32_pkg.sv
// mips32_pkg: constants and control encodings shared by the mips32 IF stage files.
//   XLEN            machine word width
//   DEF_RESET_PC    default byte address fetched first after reset
//   DEF_IMEM_DEPTH  default instruction memory depth in words
//   NOP_INSTR_WORD  bubble word (sll $0,$0,0)
//   ifid_ctrl_e     IF/ID register control: hold, load, squash
package mips32_pkg;

  localparam int unsigned XLEN           = 32;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam int unsigned DEF_IMEM_DEPTH = 128;
  localparam logic [31:0] NOP_INSTR_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFC_HOLD   = 2'd0,
    IFC_LOAD   = 2'd1,
    IFC_SQUASH = 2'd2
  } ifid_ctrl_e;

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst_n        clock, async active-low reset
//   ctrl              IFC_LOAD captures new word, IFC_SQUASH inserts a bubble
//                     (pc/pc4 hold), IFC_HOLD keeps everything
//   load_instr/pc/pc4 values captured on IFC_LOAD
//   if_id_instr/pc/pc4/valid  registered outputs to decode
module if_id_reg
  import mips32_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  ifid_ctrl_e  ctrl,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_pc4,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  // IF/ID register update: load, squash to bubble, or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= 32'h0000_0000;
      if_id_pc4   <= 32'h0000_0000;
      if_id_valid <= 1'b0;
    end else begin
      case (ctrl)
        IFC_LOAD: begin
          if_id_instr <= load_instr;
          if_id_pc    <= load_pc;
          if_id_pc4   <= load_pc4;
          if_id_valid <= 1'b1;
        end
        IFC_SQUASH: begin
          if_id_instr <= NOP_INSTR;
          if_id_valid <= 1'b0;
        end
        default: begin
          if_id_instr <= if_id_instr;
          if_id_valid <= if_id_valid;
        end
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: mips32 IF stage. Owns the PC, addresses the word-indexed
// instruction memory combinationally and registers the fetched word into IF/ID.
// Priority per edge: fault-halt > redirect > stall > advance.
//   clk, rst_n            clock, async active-low reset
//   imem_addr / imem_instr  word index out, same-cycle instruction in
//   id_stall              hold PC and IF/ID
//   redirect_valid/_pc    EX taken branch/jump target (byte address)
//   if_id_instr/pc/pc4/valid  IF/ID register to decode
//   fetch_count           instructions accepted into IF/ID (wraps)
//   fetch_fault           sticky address fault
// Build option: define ADDR_FAULT_EN to detect misaligned redirects and PCs
// beyond the memory; otherwise redirect targets are word-aligned and the PC
// aliases freely with fetch_fault tied low.
module instr_fetch_stage
  import mips32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int unsigned IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        fetch_fault
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] count_r;
  logic        count_en_s;
  ifid_ctrl_e  ctrl_s;

  assign pc_plus4_s  = pc_r + 32'd4;
  // Upper PC bits beyond the memory are dropped here, so the PC aliases
  assign imem_addr   = {{(32-AW){1'b0}}, pc_r[AW+1:2]};
  assign fetch_count = count_r;

`ifdef ADDR_FAULT_EN
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) * 33'd4;

  logic fault_r;
  logic fault_set_s;
  logic redir_bad_s;
  logic adv_bad_s;

  assign redir_bad_s = (redirect_pc[1:0] != 2'b00) || ({1'b0, redirect_pc} >= PC_LIMIT);
  assign adv_bad_s   = ({1'b0, pc_plus4_s} >= PC_LIMIT);
  assign fetch_fault = fault_r;

  // Next-PC priority mux; a detected fault squashes IF/ID and freezes the PC
  always_comb begin
    pc_next_s   = pc_r;
    ctrl_s      = IFC_HOLD;
    count_en_s  = 1'b0;
    fault_set_s = 1'b0;
    if (fault_r) begin
      ctrl_s = IFC_HOLD;
    end else if (redirect_valid) begin
      ctrl_s = IFC_SQUASH;
      if (redir_bad_s) begin
        fault_set_s = 1'b1;
      end else begin
        pc_next_s = redirect_pc;
      end
    end else if (id_stall) begin
      ctrl_s = IFC_HOLD;
    end else if (adv_bad_s) begin
      ctrl_s      = IFC_SQUASH;
      fault_set_s = 1'b1;
    end else begin
      ctrl_s     = IFC_LOAD;
      pc_next_s  = pc_plus4_s;
      count_en_s = 1'b1;
    end
  end

  // Sticky fault flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_r <= 1'b0;
    end else if (fault_set_s) begin
      fault_r <= 1'b1;
    end else begin
      fault_r <= fault_r;
    end
  end
`else
  logic [31:0] redir_target_s;

  // Byte-offset bits of the target are ignored: fetch is always word-aligned
  assign redir_target_s = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_fault    = 1'b0;

  // Next-PC priority mux: redirect beats stall beats advance
  always_comb begin
    pc_next_s  = pc_r;
    ctrl_s     = IFC_HOLD;
    count_en_s = 1'b0;
    if (redirect_valid) begin
      ctrl_s    = IFC_SQUASH;
      pc_next_s = redir_target_s;
    end else if (id_stall) begin
      ctrl_s = IFC_HOLD;
    end else begin
      ctrl_s     = IFC_LOAD;
      pc_next_s  = pc_plus4_s;
      count_en_s = 1'b1;
    end
  end
`endif

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // Fetched-instruction counter, steps only when a word enters IF/ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 32'h0000_0000;
    end else if (count_en_s) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctrl        (ctrl_s),
    .load_instr  (imem_instr),
    .load_pc     (pc_r),
    .load_pc4    (pc_plus4_s),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid)
  );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Testbench for instr_fetch_stage: table-driven vectors plus hand sequences
// for misaligned/out-of-range redirects and mid-run reset.
module tb_instr_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  logic        fetch_fault;

  int checks;
  int failures;

  // Memory model: word at index i is 0xA500_0000 | i
  assign imem_instr = 32'hA500_0000 | imem_addr;

  instr_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .if_id_valid    (if_id_valid),
    .fetch_count    (fetch_count),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic [31:0] ifpc;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge pass, then sample 1 time unit later
  task automatic step(input logic stall, input logic rv, input logic [31:0] rpc);
    id_stall       = stall;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  imem_addr,          32'h0000_0000);
    chk({tag, "_instr"}, if_id_instr,        32'h0000_0000);
    chk({tag, "_pc"},    if_id_pc,           32'h0000_0000);
    chk({tag, "_pc4"},   if_id_pc4,          32'h0000_0000);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    chk({tag, "_count"}, fetch_count,        32'h0000_0000);
    chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //           stall rv    rpc            addr   ifpc   pc4    v     instr          cnt
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h01, 32'h00, 32'h04, 1'b1, 32'hA500_0000, 32'd1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h02, 32'h04, 32'h08, 1'b1, 32'hA500_0001, 32'd2};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,        32'h02, 32'h04, 32'h08, 1'b1, 32'hA500_0001, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,        32'h02, 32'h04, 32'h08, 1'b1, 32'hA500_0001, 32'd2};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'h03, 32'h08, 32'h0C, 1'b1, 32'hA500_0002, 32'd3};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        32'h04, 32'h0C, 32'h10, 1'b1, 32'hA500_0003, 32'd4};
    vecs[6]  = '{1'b0, 1'b1, 32'h40,       32'h10, 32'h0C, 32'h10, 1'b0, 32'h0000_0000, 32'd4};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h11, 32'h40, 32'h44, 1'b1, 32'hA500_0010, 32'd5};
    vecs[8]  = '{1'b1, 1'b1, 32'h20,       32'h08, 32'h40, 32'h44, 1'b0, 32'h0000_0000, 32'd5};
    vecs[9]  = '{1'b0, 1'b1, 32'h60,       32'h18, 32'h40, 32'h44, 1'b0, 32'h0000_0000, 32'd5};
    vecs[10] = '{1'b0, 1'b1, 32'h80,       32'h20, 32'h40, 32'h44, 1'b0, 32'h0000_0000, 32'd5};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        32'h21, 32'h80, 32'h84, 1'b1, 32'hA500_0020, 32'd6};

    rst_n          = 1'b0;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    #2;
    chk_reset_vals("por");
    do_reset();
    #1;
    chk("rel_addr", imem_addr, 32'h0000_0000);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].stall, vecs[i].rv, vecs[i].rpc);
      chk($sformatf("v%0d_addr", i),  imem_addr,   vecs[i].addr);
      chk($sformatf("v%0d_pc", i),    if_id_pc,    vecs[i].ifpc);
      chk($sformatf("v%0d_pc4", i),   if_id_pc4,   vecs[i].pc4);
      chk($sformatf("v%0d_valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].valid});
      chk($sformatf("v%0d_instr", i), if_id_instr, vecs[i].instr);
      chk($sformatf("v%0d_count", i), fetch_count, vecs[i].cnt);
      chk($sformatf("v%0d_fault", i), {31'd0, fetch_fault}, 32'd0);
    end

    // pc is now 0x84, fetch_count 6
`ifdef ADDR_FAULT_EN
    step(1'b0, 1'b1, 32'h42);
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_valid", {31'd0, if_id_valid}, 32'd0);
    chk("mis_instr", if_id_instr, 32'h0000_0000);
    chk("mis_addr",  imem_addr,   32'h21);
    step(1'b0, 1'b1, 32'h0);
    chk("flt_redir_addr", imem_addr, 32'h21);
    chk("flt_fault",      {31'd0, fetch_fault}, 32'd1);
    step(1'b0, 1'b0, 32'h0);
    chk("flt_adv_addr",  imem_addr,   32'h21);
    chk("flt_adv_count", fetch_count, 32'd6);
    chk("flt_adv_valid", {31'd0, if_id_valid}, 32'd0);
    do_reset();
    step(1'b0, 1'b1, 32'h200);
    chk("oor_fault", {31'd0, fetch_fault}, 32'd1);
    chk("oor_addr",  imem_addr, 32'h0);
    do_reset();
    step(1'b0, 1'b1, 32'h1FC);
    chk("last_addr", imem_addr, 32'h7F);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap_fault", {31'd0, fetch_fault}, 32'd1);
    chk("wrap_addr",  imem_addr, 32'h7F);
    chk("wrap_valid", {31'd0, if_id_valid}, 32'd0);
    chk("wrap_count", fetch_count, 32'd0);
`else
    step(1'b0, 1'b1, 32'h42);
    chk("mis_addr",  imem_addr, 32'h10);
    chk("mis_valid", {31'd0, if_id_valid}, 32'd0);
    chk("mis_fault", {31'd0, fetch_fault}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    chk("mis_pc",    if_id_pc,    32'h40);
    chk("mis_instr", if_id_instr, 32'hA500_0010);
    chk("mis_count", fetch_count, 32'd7);
    step(1'b0, 1'b1, 32'h1FC);
    chk("last_addr", imem_addr, 32'h7F);
    step(1'b0, 1'b0, 32'h0);
    chk("last_pc",    if_id_pc,    32'h1FC);
    chk("last_pc4",   if_id_pc4,   32'h200);
    chk("last_instr", if_id_instr, 32'hA500_007F);
    chk("alias_addr", imem_addr,   32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("alias_pc",    if_id_pc,    32'h200);
    chk("alias_instr", if_id_instr, 32'hA500_0000);
    chk("alias_count", fetch_count, 32'd9);
    chk("alias_fault", {31'd0, fetch_fault}, 32'd0);
`endif

    // Mid-run asynchronous reset at pc=0x18
    do_reset();
    step(1'b0, 1'b1, 32'h14);
    step(1'b0, 1'b0, 32'h0);
    chk("pre_rst_addr",  imem_addr,   32'h06);
    chk("pre_rst_count", fetch_count, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_addr", imem_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("post_rst_pc",    if_id_pc,    32'h0);
    chk("post_rst_valid", {31'd0, if_id_valid}, 32'd1);
    chk("post_rst_count", fetch_count, 32'd1);
    chk("post_rst_naddr", imem_addr,   32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
